// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, WIDTH-bit operands, signed/unsigned at run time
// Ports: clck clock; rst async active-low reset; go start request; sgn 1=signed 0=unsigned;
//        Abus multiplicand; Bbus multiplier; Rbus held 2*WIDTH product; done 1-cycle completion; busy computing
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clck,
  input  logic               rst,
  input  logic               go,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   Abus,
  input  logic [WIDTH-1:0]   Bbus,
  output logic [2*WIDTH-1:0] Rbus,
  output logic               done,
  output logic               busy
);
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t             state_q, state_d;
  logic [WIDTH+1:0]   acc_q, acc_d, m_q, m_d, sum;
  logic [WIDTH:0]     q_q, q_d;
  logic               q1_q, q1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] r_q, r_d;
  logic [2*WIDTH+2:0] step;
  // Booth pair {Q0, Q-1}: 01 adds, 10 subtracts the multiplicand
  assign sum  = ({q_q[0], q1_q} == 2'b01) ? acc_q + m_q :
                ({q_q[0], q1_q} == 2'b10) ? acc_q - m_q : acc_q;
  // arithmetic right shift of {acc, Q}; Q-1 takes the bit shifted out
  assign step = {sum[WIDTH+1], sum, q_q[WIDTH:1]};
  assign Rbus = r_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    done    = state_q == DONE;
    busy    = state_q == CALC;
    if (state_q != CALC && go) begin
      m_d     = {{2{sgn & Abus[WIDTH-1]}}, Abus};
      q_d     = {sgn & Bbus[WIDTH-1], Bbus};
      acc_d   = '0;
      q1_d    = 1'b0;
      cnt_d   = '0;
      state_d = CALC;
    end else if (state_q == CALC) begin
      acc_d = step[2*WIDTH+2:WIDTH+1];
      q_d   = step[WIDTH:0];
      q1_d  = q_q[0];
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(WIDTH)) begin
        r_d     = step[2*WIDTH-1:0];
        state_d = DONE;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clck or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: checks booth_mult_seq (WIDTH 8 and 16) against an arithmetic product model
module tb_booth_mult_seq;
  logic        clck = 1'b0, rst = 1'b0, go = 1'b0, sgn = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic [15:0] r8;
  logic        done8, busy8;
  logic        go16 = 1'b0, sgn16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic [31:0] r16;
  logic        done16, busy16;
  int          checks = 0, failures = 0;

  always #5 clck = ~clck;

  booth_mult_seq #(.WIDTH(8)) u8 (
    .clck(clck), .rst(rst), .go(go), .sgn(sgn), .Abus(a), .Bbus(b),
    .Rbus(r8), .done(done8), .busy(busy8)
  );
  booth_mult_seq #(.WIDTH(16)) u16 (
    .clck(clck), .rst(rst), .go(go16), .sgn(sgn16), .Abus(a16), .Bbus(b16),
    .Rbus(r16), .done(done16), .busy(busy16)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] prod(input bit s, input logic [15:0] x, input logic [15:0] y, input int w);
    longint xa, ya, p;
    xa = longint'(x);
    ya = longint'(y);
    if (s && x[w-1]) xa = xa - (longint'(1) << w);
    if (s && y[w-1]) ya = ya - (longint'(1) << w);
    p = xa * ya;
    return (w == 8) ? {16'h0, p[15:0]} : p[31:0];
  endfunction

  // cycle model of the 8-bit unit: an accepted start completes WIDTH+1 edges later
  int          e = 0, m_fin = 0;
  bit          m_act = 0, m_done = 0;
  logic [15:0] m_pend = '0, m_r = '0;
  logic [31:0] m_t;
  always @(posedge clck or negedge rst) begin
    if (!rst) begin
      m_act  = 0;
      m_done = 0;
      m_r    = '0;
    end else begin
      m_done = 0;
      if (m_act) begin
        if (e == m_fin) begin
          m_r    = m_pend;
          m_act  = 0;
          m_done = 1;
        end
      end else if (go) begin
        m_t    = prod(sgn, {8'h0, a}, {8'h0, b}, 8);
        m_pend = m_t[15:0];
        m_act  = 1;
        m_fin  = e + 9;
      end
      e++;
    end
  end

  always @(negedge clck) begin
    check("rbus", r8, m_r);
    check("done", done8, m_done);
    check("busy", busy8, m_act);
    check("busy_in_done", done8 & busy8, 0);
  end

  task automatic op8(input bit s, input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp, input string nm);
    int n;
    go = 1; sgn = s; a = x; b = y;
    @(posedge clck); #1 go = 0;
    n = 0;
    @(negedge clck);
    while (!done8 && n < 40) begin @(negedge clck); n++; end
    check({nm, "_lat"}, n, 9);
    check(nm, r8, exp);
    @(posedge clck); #1;
  endtask

  task automatic op16(input bit s, input logic [15:0] x, input logic [15:0] y, input logic [31:0] exp, input string nm);
    int n;
    go16 = 1; sgn16 = s; a16 = x; b16 = y;
    @(posedge clck); #1 go16 = 0;
    n = 0;
    @(negedge clck);
    while (!done16 && n < 60) begin @(negedge clck); n++; end
    check({nm, "_lat"}, n, 17);
    check(nm, r16, exp);
    @(posedge clck); #1;
  endtask

  initial begin
    int n, seen;
    time t1;
    logic [31:0] t;
    bit s;
    logic [7:0] x, y;
    logic [15:0] x16, y16;
    repeat (2) @(posedge clck);
    #1;
    check("rst_r8", r8, 0);
    check("rst_done8", done8, 0);
    check("rst_busy8", busy8, 0);
    check("rst_r16", r16, 0);
    rst = 1;
    @(posedge clck); #1;
    op8(1, 8'hEA, 8'h64, 16'hF768, "m22x100");
    op8(1, 8'h16, 8'h9C, 16'hF768, "22xm100");
    op8(1, 8'hEA, 8'h9C, 16'h0898, "m22xm100");
    op8(1, 8'h16, 8'h64, 16'h0898, "22x100");
    op8(1, 8'h80, 8'h80, 16'h4000, "s80x80");
    op8(0, 8'hFF, 8'hFF, 16'hFE01, "uFFxFF");
    op8(0, 8'h80, 8'h02, 16'h0100, "u80x02");
    // go held high; operand change mid-run must not disturb the first op
    sgn = 0; a = 8'd3; b = 8'd5; go = 1;
    @(posedge clck); #1 a = 8'd7;
    n = 0;
    @(negedge clck);
    while (!done8 && n < 40) begin @(negedge clck); n++; end
    check("b2b_first", r8, 16'd15);
    t1 = $time;
    @(negedge clck);
    check("b2b_nogap", busy8, 1);
    n = 0;
    while (!done8 && n < 40) begin @(negedge clck); n++; end
    check("b2b_period", ($time - t1) / 10, 10);
    check("b2b_second", r8, 16'd35);
    go = 0;
    @(posedge clck); #1;
    // reset four cycles into a run
    a = 8'd9; b = 8'd9; go = 1;
    @(posedge clck); #1 go = 0;
    repeat (4) @(posedge clck);
    #1 rst = 0;
    #1;
    check("abort_r8", r8, 0);
    check("abort_done", done8, 0);
    check("abort_busy", busy8, 0);
    @(posedge clck); #1 rst = 1;
    seen = 0;
    repeat (12) begin @(negedge clck); seen += int'(done8); end
    check("abort_no_done", seen, 0);
    @(posedge clck); #1;
    op8(1, 8'd2, 8'd7, 16'h000E, "after_abort");
    op16(1, 16'hFED4, 16'd7, 32'hFFFFF7CC, "w16_m300x7");
    op16(0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, "w16_uFFFF");
    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom);
      x = 8'($urandom);
      y = 8'($urandom);
      t = prod(s, {8'h0, x}, {8'h0, y}, 8);
      op8(s, x, y, t[15:0], "rnd8");
    end
    for (int i = 0; i < 40; i++) begin
      s = 1'($urandom);
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      op16(s, x16, y16, prod(s, x16, y16, 16), "rnd16");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier.
- Next generation of the team's 8-bit shift-add multiplier datapath/controller pair, generalised to WIDTH-bit operands.
- Adds a run-time signed/unsigned mode, a busy flag, back-to-back start capability and a held result register.
- Sits behind the same go/done handshake so existing controllers can drive it unchanged.

Parameters:
- WIDTH, 8, operand width in bits (>=4). Result width is 2*WIDTH. Iteration counter width is clog2(WIDTH+2), derived internally.

Ports:
- clck  input  1  system clock, rising-edge active
- rst  input  1  asynchronous reset, active-low (rst=0 resets)
- go  input  1  start request, sampled on rising clck
- sgn  input  1  1 = operands two's-complement, 0 = unsigned; sampled with go
- Abus  input  WIDTH  multiplicand, sampled with go
- Bbus  input  WIDTH  multiplier, sampled with go
- Rbus  output  2*WIDTH  product, registered, held until next completion
- done  output  1  one-cycle completion pulse
- busy  output  1  high while an operation is in progress

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; Rbus=0, done=0, busy=0.
  - Internal accumulator, operand registers and counter cleared.
  - Release is synchronous to the next clck edge.
- States: IDLE, CALC, DONE.
- IDLE:
  - done=0, busy=0.
  - On an edge with go=1: latch Abus, Bbus and sgn; counter=0; go to CALC.
  - Operands are extended to WIDTH+1 bits: sign-extended if sgn=1, zero-extended if sgn=0.
- CALC:
  - busy=1. Each edge performs one Booth step on the (WIDTH+1)-bit multiplier with appended Q(-1)=0:
    - pair 01: add multiplicand;
    - pair 10: subtract multiplicand;
    - 00/11: no add;
    - then arithmetic right shift of {acc, Q, Q(-1)}.
  - Accumulator is WIDTH+2 bits wide so that -2^(WIDTH-1) and unsigned maxima never overflow.
  - Counter increments each step. On the edge completing step WIDTH+1:
    - load Rbus with the low 2*WIDTH bits of the product;
    - go to DONE.
- DONE:
  - done=1 and busy=0 for exactly one cycle; Rbus is valid from this cycle on.
  - Next edge: if go=1, latch new operands and enter CALC (back-to-back start, no IDLE cycle); else go to IDLE.
- Latency: go sampled at edge k gives done=1 during the cycle after edge k+WIDTH+1. For WIDTH=8 this is 9 cycles; the throughput period is WIDTH+2 cycles.
- go while in CALC is ignored; operands and sgn must not change the running operation.
- go held high continuously restarts on every DONE cycle.
- Rbus changes only on the completing CALC edge and on reset; it holds otherwise.
- Result is exact for all operand pairs in both modes. Signed result is the two's-complement 2*WIDTH product; unsigned result is the zero-extended product.
- rst asserted mid-CALC: abort immediately, outputs return to reset values, and no done pulse is issued for the aborted operation.
- Operands containing X/Z are not supported.

Test Plan:
- WIDTH=8, sgn=1, reset pulse, then go for one cycle:
  - Abus=-22, Bbus=100 -> done after 9 cycles, Rbus=16'hF768;
  - repeat with Abus=22, Bbus=-100 -> 16'hF768;
  - Abus=-22, Bbus=-100 -> 16'h0898;
  - Abus=22, Bbus=100 -> 16'h0898.
- WIDTH=8 corner cases:
  - sgn=1, Abus=8'h80, Bbus=8'h80 -> Rbus=16'h4000;
  - sgn=0, Abus=8'hFF, Bbus=8'hFF -> Rbus=16'hFE01;
  - sgn=0, Abus=8'h80, Bbus=8'h02 -> Rbus=16'h0100.
- go held high with operands changed during CALC (Abus=3, Bbus=5 then Abus=7):
  - first done gives Rbus=15;
  - back-to-back op starts in the DONE cycle with no IDLE gap;
  - busy never high in a done cycle;
  - done period = 10 cycles.
- rst driven to 0 four cycles into CALC:
  - Rbus=0, done=0, busy=0 immediately, no done pulse;
  - then go with 2*7 -> Rbus=16'h000E after 9 cycles.
- WIDTH=16, sgn=1, Abus=-300, Bbus=7 -> done after 17 cycles, Rbus=32'hFFFFF7CC.
- WIDTH=16, sgn=0, Abus=16'hFFFF, Bbus=16'hFFFF -> Rbus=32'hFFFE0001.
- Randomised cross-check against a behavioural product, both modes, 1000 operand pairs.
